irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Machine-mode interrupt controller that sequences the CSR/trap datapath.
- Masks platform interrupt lines with the mie CSR value and picks one request by fixed priority.
- Raises a one-cycle interrupt trap with its mcause value, which the CSR block captures together with the trap PC.
- Tracks exception and interrupt handler nesting until mret, then sends a one-cycle acknowledge back to the serviced peripheral.

Parameters:
- NUM_IRQ, 16, number of platform interrupt lines; legal range 1..16.
- IRQ_CAUSE_BASE, 16, mcause code of line 0; line k reports code IRQ_CAUSE_BASE+k.

Ports:
- clk_i  input  1  system clock; all state changes on posedge.
- rst_i  input  1  synchronous, active-high reset.
- exception_i  input  1  core detected a synchronous exception this cycle (illegal instruction etc.).
- mret_i  input  1  core is executing mret this cycle.
- irq_req_i  input  NUM_IRQ  level-sensitive interrupt requests; bit k = line k.
- mie_i  input  32  current mie CSR value; bit 16+k enables line k.
- irq_o  output  1  interrupt trap request to core/CSR (trap_i source); one-cycle pulse.
- irq_cause_o  output  32  mcause value for the interrupt; valid while irq_o=1.
- irq_ret_o  output  NUM_IRQ  one-hot, one-cycle acknowledge to the serviced line.
- busy_o  output  1  a trap handler (exception or interrupt) is active.

Behaviour:
- One clock (clk_i); reset is synchronous and active-high (rst_i).
- Reset: state=IDLE, active index=0; irq_o=0, irq_cause_o=0, irq_ret_o=0, busy_o=0.
- Reset mid-handler: next cycle is IDLE with no irq_ret_o pulse.
- pending = irq_req_i & mie_i[16 +: NUM_IRQ].
- Winner = lowest set index of pending; line 0 has the highest priority.
- States: IDLE, EXC, IRQ, IRQ_EXC, RET. busy_o=1 in every state except IDLE.
- IDLE, exception_i=1:
  - Go to EXC. irq_o=0, even if pending!=0.
- IDLE, exception_i=0 and pending!=0:
  - irq_o=1 combinationally, same cycle.
  - irq_cause_o = {1'b1, 31'(IRQ_CAUSE_BASE+winner)}.
  - Register winner as the active index; go to IRQ.
- IDLE otherwise: irq_o=0, irq_cause_o=0.
- EXC:
  - mret_i=1 -> IDLE.
  - exception_i stays in EXC; nested exceptions are not tracked.
  - Interrupts are blocked.
- IRQ:
  - exception_i=1 -> IRQ_EXC.
  - else mret_i=1 -> RET.
  - Interrupts are blocked; a higher-priority request waits (no preemption).
- IRQ_EXC:
  - mret_i=1 -> IRQ; the exception returns into the interrupt handler and no ack is sent.
  - exception_i stays in IRQ_EXC.
- RET:
  - irq_ret_o[active index]=1 for exactly this one cycle; irq_o is forced 0.
  - This cooldown cycle lets the peripheral drop its request.
  - Next state: exception_i ? EXC : IDLE.
- exception_i and mret_i high in the same cycle: exception_i wins and mret_i is ignored.
- Latency:
  - Request to irq_o: 0 cycles when IDLE with mie set.
  - mret to irq_ret_o: 1 cycle.
  - Minimum request-to-request spacing on one line: mret + 2 cycles.
- Changing mie_i only affects arbitration in IDLE; an active handler is never cancelled.
- irq_cause_o outside irq_o=1 is 0.
- Illegal or unreachable state encodings recover to IDLE.

Test Plan:
- Reset, then mie_i=0x0001_0000 and irq_req_i[0]=1 -> irq_o=1 in the same cycle, irq_cause_o=0x8000_0010. Next cycle irq_o=0, busy_o=1.
- irq_req_i=0x0006 with mie_i=0x0006_0000 -> line 1 wins, irq_cause_o=0x8000_0011.
  - mret_i pulse -> irq_ret_o=0x0002 one cycle later for one cycle.
  - Line 2 then traps one cycle after that with cause 0x8000_0012.
- irq_req_i=0x0001 with mie_i=0 -> irq_o stays 0 for 10 cycles. Setting mie_i[16] -> irq_o=1 the same cycle.
- Within an IRQ handler:
  - exception_i pulse, then mret_i -> no irq_ret_o, busy_o stays 1.
  - A second mret_i -> irq_ret_o pulse, then IDLE.
- exception_i and irq_req_i[3]=1 (enabled) in the same IDLE cycle -> irq_o=0, state EXC.
  - mret_i -> IDLE; next cycle irq_o=1 with cause 0x8000_0013.
- rst_i asserted while in IRQ -> no irq_ret_o pulse, busy_o=0 next cycle, all outputs 0.

Source files
------------

// File: rtl/irq_controller.sv
// Machine-mode interrupt controller: masks, arbitrates and sequences
// interrupt traps, tracks handler nesting and acknowledges on return.
module irq_controller #(
    parameter int NUM_IRQ        = 16,
    parameter int IRQ_CAUSE_BASE = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               exception_i,
    input  logic               mret_i,
    input  logic [NUM_IRQ-1:0] irq_req_i,
    input  logic [31:0]        mie_i,
    output logic               irq_o,
    output logic [31:0]        irq_cause_o,
    output logic [NUM_IRQ-1:0] irq_ret_o,
    output logic               busy_o
);

    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXC     = 3'd1,
        S_IRQ     = 3'd2,
        S_IRQ_EXC = 3'd3,
        S_RET     = 3'd4
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic [IW-1:0]        active_q;
    logic [IW-1:0]        active_d;
    logic [NUM_IRQ-1:0]   pending;
    logic [IW-1:0]        winner;
    logic                 any_pending;
    logic [30:0]          cause_code;
    logic [NUM_IRQ-1:0]   ret_mask;

    // Mask requests with mie and pick the lowest-numbered line.
    always_comb begin
        pending     = irq_req_i & mie_i[16 +: NUM_IRQ];
        any_pending = |pending;
        winner      = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                winner = IW'(i);
            end
        end
        cause_code = 31'(IRQ_CAUSE_BASE) + 31'(winner);
        ret_mask   = NUM_IRQ'(1) << active_q;
    end

    // Next-state and output decode; exceptions always beat mret.
    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        irq_o       = 1'b0;
        irq_cause_o = 32'h0;
        irq_ret_o   = '0;
        busy_o      = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (exception_i) begin
                    state_d = S_EXC;
                end else if (any_pending) begin
                    irq_o       = 1'b1;
                    irq_cause_o = {1'b1, cause_code};
                    active_d    = winner;
                    state_d     = S_IRQ;
                end
            end
            S_EXC: begin
                if (!exception_i && mret_i) begin
                    state_d = S_IDLE;
                end
            end
            S_IRQ: begin
                if (exception_i) begin
                    state_d = S_IRQ_EXC;
                end else if (mret_i) begin
                    state_d = S_RET;
                end
            end
            S_IRQ_EXC: begin
                if (!exception_i && mret_i) begin
                    state_d = S_IRQ;
                end
            end
            S_RET: begin
                irq_ret_o = ret_mask;
                state_d   = exception_i ? S_EXC : S_IDLE;
            end
            default: begin
                busy_o   = 1'b0;
                state_d  = S_IDLE;
                active_d = '0;
            end
        endcase
        if (rst_i) begin
            irq_o       = 1'b0;
            irq_cause_o = 32'h0;
            irq_ret_o   = '0;
            busy_o      = 1'b0;
        end
    end

    // State and active-line registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Randomised and directed bench for irq_controller, checked against a
// flag-based model of handler nesting and acknowledge timing.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc;
    logic        mret;
    logic [15:0] req;
    logic [31:0] mie;
    logic        irq_o;
    logic [31:0] irq_cause_o;
    logic [15:0] irq_ret_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    irq_controller #(.NUM_IRQ(16), .IRQ_CAUSE_BASE(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .exception_i (exc),
        .mret_i      (mret),
        .irq_req_i   (req),
        .mie_i       (mie),
        .irq_o       (irq_o),
        .irq_cause_o (irq_cause_o),
        .irq_ret_o   (irq_ret_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Model: in exception handler, in interrupt handler, ack owed.
    logic m_exc  = 1'b0;
    logic m_irq  = 1'b0;
    logic m_ack  = 1'b0;
    int   m_line = 0;
    logic m_ok   = 1'b0;

    function automatic int first_set(input logic [15:0] v);
        for (int k = 0; k < 16; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [15:0] pend();
        return req & mie[31:16];
    endfunction

    function automatic logic e_irq();
        return !rst && !m_exc && !m_irq && !m_ack && !exc
               && (pend() != 16'h0);
    endfunction

    function automatic logic [31:0] e_cause();
        if (!e_irq()) return 32'h0;
        return 32'h8000_0000 + 32'(16 + first_set(pend()));
    endfunction

    function automatic logic [15:0] e_ret();
        logic [15:0] one;
        one = 16'h1;
        if (rst || !m_ack) return 16'h0;
        return one << m_line;
    endfunction

    function automatic logic e_busy();
        return !rst && (m_exc || m_irq || m_ack);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    // Model update on every clock edge.
    always @(posedge clk) begin
        if (rst) begin
            m_exc <= 1'b0;
            m_irq <= 1'b0;
            m_ack <= 1'b0;
            m_line <= 0;
            m_ok <= 1'b1;
        end else if (m_ack) begin
            m_ack <= 1'b0;
            m_irq <= 1'b0;
            m_exc <= exc;
        end else if (m_exc) begin
            if (!exc && mret) m_exc <= 1'b0;
        end else if (m_irq) begin
            if (exc) m_exc <= 1'b1;
            else if (mret) m_ack <= 1'b1;
        end else if (exc) begin
            m_exc <= 1'b1;
        end else if (pend() != 16'h0) begin
            m_irq <= 1'b1;
            m_line <= first_set(pend());
        end
    end

    // Compare every output against the model each cycle.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("irq_o", 32'(irq_o), 32'(e_irq()));
            chk("cause", irq_cause_o, e_cause());
            chk("ret", 32'(irq_ret_o), 32'(e_ret()));
            chk("busy", 32'(busy_o), 32'(e_busy()));
        end
    end

    task automatic cyc(input logic r, input logic e, input logic m,
                       input logic [15:0] q, input logic [31:0] ie);
        @(posedge clk);
        #1;
        rst = r; exc = e; mret = m; req = q; mie = ie;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; exc = 1'b0; mret = 1'b0; req = '0; mie = '0;
        cyc(1, 0, 0, 16'h0, 32'h0);
        cyc(1, 0, 0, 16'h1, 32'h1_0000);
        chk("rst_irq", 32'(irq_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);

        cyc(0, 0, 0, 16'h1, 32'h1_0000);
        chk("t1_irq", 32'(irq_o), 32'h1);
        chk("t1_cause", irq_cause_o, 32'h8000_0010);
        cyc(0, 0, 0, 16'h0, 32'h1_0000);
        chk("t1_irq2", 32'(irq_o), 32'h0);
        chk("t1_busy", 32'(busy_o), 32'h1);
        cyc(0, 0, 1, 16'h0, 32'h1_0000);
        chk("t1_noret", 32'(irq_ret_o), 32'h0);
        cyc(0, 0, 0, 16'h0, 32'h1_0000);
        chk("t1_ret", 32'(irq_ret_o), 32'h1);
        cyc(0, 0, 0, 16'h0, 32'h1_0000);
        chk("t1_idle", 32'(busy_o), 32'h0);

        cyc(0, 0, 0, 16'h6, 32'h6_0000);
        chk("t2_cause", irq_cause_o, 32'h8000_0011);
        cyc(0, 0, 0, 16'h6, 32'h6_0000);
        cyc(0, 0, 1, 16'h6, 32'h6_0000);
        cyc(0, 0, 0, 16'h4, 32'h6_0000);
        chk("t2_ret", 32'(irq_ret_o), 32'h2);
        chk("t2_cool", 32'(irq_o), 32'h0);
        cyc(0, 0, 0, 16'h4, 32'h6_0000);
        chk("t2_ret0", 32'(irq_ret_o), 32'h0);
        chk("t2_cause2", irq_cause_o, 32'h8000_0012);
        cyc(0, 0, 1, 16'h0, 32'h6_0000);
        cyc(0, 0, 0, 16'h0, 32'h6_0000);
        chk("t2_ret2", 32'(irq_ret_o), 32'h4);
        cyc(0, 0, 0, 16'h0, 32'h0);

        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 16'h1, 32'h0);
            chk("t3_masked", 32'(irq_o), 32'h0);
        end
        cyc(0, 0, 0, 16'h1, 32'h1_0000);
        chk("t3_irq", 32'(irq_o), 32'h1);
        cyc(0, 1, 0, 16'h0, 32'h1_0000);
        cyc(0, 0, 1, 16'h0, 32'h1_0000);
        cyc(0, 0, 0, 16'h0, 32'h1_0000);
        chk("t4_noret", 32'(irq_ret_o), 32'h0);
        chk("t4_busy", 32'(busy_o), 32'h1);
        cyc(0, 0, 1, 16'h0, 32'h1_0000);
        cyc(0, 0, 0, 16'h0, 32'h1_0000);
        chk("t4_ret", 32'(irq_ret_o), 32'h1);
        cyc(0, 0, 0, 16'h0, 32'h1_0000);
        chk("t4_idle", 32'(busy_o), 32'h0);

        cyc(0, 1, 0, 16'h8, 32'h8_0000);
        chk("t5_exc", 32'(irq_o), 32'h0);
        cyc(0, 0, 0, 16'h8, 32'h8_0000);
        chk("t5_blk", 32'(irq_o), 32'h0);
        cyc(0, 0, 1, 16'h8, 32'h8_0000);
        cyc(0, 0, 0, 16'h8, 32'h8_0000);
        chk("t5_cause", irq_cause_o, 32'h8000_0013);

        cyc(1, 0, 0, 16'h0, 32'h8_0000);
        cyc(0, 0, 0, 16'h0, 32'h8_0000);
        chk("t6_ret", 32'(irq_ret_o), 32'h0);
        chk("t6_busy", 32'(busy_o), 32'h0);
        chk("t6_irq", 32'(irq_o), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 5) == 0),
                16'($urandom & $urandom),
                ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
